// File: rtl/lstm_mac_sequencer.sv
// Dot-product sequencer for the LSTM block: streams x/w from SRAM, accumulates, writes results.
// Optional macro LSTM_MAC_SAT_EN selects saturating (instead of wrapping) result conversion.
module lstm_mac_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FRAC_W  = 8,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned NUM_OUT = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_xxx_busy,
    output logic              x_rd_en,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              dut_computation_done
);

    localparam int unsigned I_W    = $clog2(VEC_LEN + 1);
    localparam int unsigned J_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        STORE,
        DONE,
        WAIT_CLR
    } state_t;

    state_t                     state, state_nxt;
    logic        [I_W-1:0]      i, i_nxt;
    logic        [J_W-1:0]      j, j_nxt;
    logic signed [ACC_W-1:0]    acc, acc_nxt;
    logic                       vld;
    logic                       x_rd_en_nxt, w_rd_en_nxt, res_we_nxt, done_nxt;
    logic        [ADDR_W-1:0]   x_addr_nxt, w_addr_nxt, res_addr_nxt;
    logic        [DATA_W-1:0]   res_data_nxt;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic        [DATA_W-1:0]   res_conv;

    // Weight address j*VEC_LEN+i, truncated to the SRAM address width.
    function automatic logic [ADDR_W-1:0] w_index(input logic [J_W-1:0] jj,
                                                  input logic [I_W-1:0] ii);
        return ADDR_W'(jj) * ADDR_W'(VEC_LEN) + ADDR_W'(ii);
    endfunction

    // Accumulate the product of the data returned for last cycle's read, if any.
    always_comb begin
        prod    = PROD_W'($signed(x_rd_data)) * PROD_W'($signed(w_rd_data));
        acc_sum = acc;
        if (vld) begin
            acc_sum = acc + ACC_W'(prod);
        end
    end

`ifdef LSTM_MAC_SAT_EN
    logic signed [ACC_W-1:0] shifted;

    // Clamp to the signed DATA_W range when the upper bits are not pure sign extension.
    always_comb begin
        shifted  = acc_sum >>> FRAC_W;
        res_conv = shifted[DATA_W-1:0];
        if (!((shifted[ACC_W-1:DATA_W-1] == '0) || (shifted[ACC_W-1:DATA_W-1] == '1))) begin
            res_conv = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_conv = DATA_W'(acc_sum >>> FRAC_W);
    end
`endif

    // State and output registers; outputs are loaded with the values for the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state                <= IDLE;
            i                    <= '0;
            j                    <= '0;
            acc                  <= '0;
            vld                  <= 1'b0;
            x_rd_en              <= 1'b0;
            w_rd_en              <= 1'b0;
            x_addr               <= '0;
            w_addr               <= '0;
            res_we               <= 1'b0;
            res_addr             <= '0;
            res_data             <= '0;
            dut_computation_done <= 1'b0;
        end else begin
            state                <= state_nxt;
            i                    <= i_nxt;
            j                    <= j_nxt;
            acc                  <= acc_nxt;
            vld                  <= x_rd_en;
            x_rd_en              <= x_rd_en_nxt;
            w_rd_en              <= w_rd_en_nxt;
            x_addr               <= x_addr_nxt;
            w_addr               <= w_addr_nxt;
            res_we               <= res_we_nxt;
            res_addr             <= res_addr_nxt;
            res_data             <= res_data_nxt;
            dut_computation_done <= done_nxt;
        end
    end

    // Next state and next output values; i is the index of the next read to issue.
    always_comb begin
        state_nxt    = state;
        i_nxt        = i;
        j_nxt        = j;
        acc_nxt      = acc;
        x_rd_en_nxt  = 1'b0;
        w_rd_en_nxt  = 1'b0;
        x_addr_nxt   = x_addr;
        w_addr_nxt   = w_addr;
        res_we_nxt   = 1'b0;
        res_addr_nxt = res_addr;
        res_data_nxt = res_data;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                i_nxt   = '0;
                j_nxt   = '0;
                acc_nxt = '0;
                if (dut_xxx_busy) begin
                    state_nxt   = FETCH;
                    x_rd_en_nxt = 1'b1;
                    w_rd_en_nxt = 1'b1;
                    x_addr_nxt  = '0;
                    w_addr_nxt  = '0;
                    i_nxt       = I_W'(1);
                end
            end

            FETCH: begin
                if (!dut_xxx_busy) begin
                    state_nxt = IDLE;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    acc_nxt   = '0;
                end else begin
                    acc_nxt = acc_sum;
                    if (i == I_W'(VEC_LEN)) begin
                        state_nxt = DRAIN;
                    end else begin
                        x_rd_en_nxt = 1'b1;
                        w_rd_en_nxt = 1'b1;
                        x_addr_nxt  = ADDR_W'(i);
                        w_addr_nxt  = w_index(j, i);
                        i_nxt       = i + I_W'(1);
                    end
                end
            end

            DRAIN: begin
                if (!dut_xxx_busy) begin
                    state_nxt = IDLE;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    acc_nxt   = '0;
                end else begin
                    state_nxt    = STORE;
                    acc_nxt      = acc_sum;
                    res_we_nxt   = 1'b1;
                    res_addr_nxt = ADDR_W'(j);
                    res_data_nxt = res_conv;
                end
            end

            STORE: begin
                if (!dut_xxx_busy) begin
                    state_nxt = IDLE;
                    i_nxt     = '0;
                    j_nxt     = '0;
                    acc_nxt   = '0;
                end else if (j == J_W'(NUM_OUT - 1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt   = FETCH;
                    j_nxt       = j + J_W'(1);
                    acc_nxt     = '0;
                    x_rd_en_nxt = 1'b1;
                    w_rd_en_nxt = 1'b1;
                    x_addr_nxt  = '0;
                    w_addr_nxt  = w_index(j + J_W'(1), '0);
                    i_nxt       = I_W'(1);
                end
            end

            DONE: begin
                state_nxt = WAIT_CLR;
            end

            WAIT_CLR: begin
                // Hold here until busy drops so a held run request cannot restart the sequence.
                if (!dut_xxx_busy) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lstm_mac_sequencer.sv
// Directed bench for lstm_mac_sequencer with VEC_LEN=4, NUM_OUT=2 and 1-cycle-latency SRAM models.
module tb_lstm_mac_sequencer;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned ACC_W   = 40;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned NUM_OUT = 2;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              busy;
    logic              x_rd_en, w_rd_en, res_we, done;
    logic [ADDR_W-1:0] x_addr, w_addr, res_addr;
    logic [DATA_W-1:0] x_rd_data, w_rd_data, res_data;

    logic [DATA_W-1:0] xmem [0:15];
    logic [DATA_W-1:0] wmem [0:15];

    int vectors     = 0;
    int miscompares = 0;

    int                wr_cnt, done_cnt, done_cyc, rd_cnt;
    int                wr_cyc  [4];
    logic [DATA_W-1:0] wr_data [4];
    logic [ADDR_W-1:0] wr_addr [4];
    logic [ADDR_W-1:0] rd_x    [8];
    logic [ADDR_W-1:0] rd_w    [8];

    always #5 clk = ~clk;

    lstm_mac_sequencer #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W),
        .VEC_LEN(VEC_LEN),
        .NUM_OUT(NUM_OUT)
    ) u_dut (
        .clk                 (clk),
        .reset_b             (reset_b),
        .dut_xxx_busy        (busy),
        .x_rd_en             (x_rd_en),
        .x_addr              (x_addr),
        .x_rd_data           (x_rd_data),
        .w_rd_en             (w_rd_en),
        .w_addr              (w_addr),
        .w_rd_data           (w_rd_data),
        .res_we              (res_we),
        .res_addr            (res_addr),
        .res_data            (res_data),
        .dut_computation_done(done)
    );

    // Synchronous-read SRAM models: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (x_rd_en) x_rd_data <= xmem[x_addr[3:0]];
        if (w_rd_en) w_rd_data <= wmem[w_addr[3:0]];
    end

    // Raise busy and observe ncyc cycles; cycle n is sampled just after the n-th edge since busy rose.
    task automatic do_run(input int ncyc);
        wr_cnt   = 0;
        done_cnt = 0;
        done_cyc = 0;
        rd_cnt   = 0;
        busy     = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            if (x_rd_en) begin
                if (rd_cnt < 8) begin
                    rd_x[rd_cnt] = x_addr;
                    rd_w[rd_cnt] = w_addr;
                end
                rd_cnt++;
            end
            if (res_we) begin
                if (wr_cnt < 4) begin
                    wr_cyc[wr_cnt]  = n;
                    wr_data[wr_cnt] = res_data;
                    wr_addr[wr_cnt] = res_addr;
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = n;
            end
        end
    endtask

    task automatic idle_gap();
        busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic load_basic();
        xmem[0] = 16'd256;
        xmem[1] = 16'd512;
        xmem[2] = 16'd768;
        xmem[3] = 16'd1024;
        for (int k = 0; k < 4; k++) begin
            wmem[k]     = 16'h0100;
            wmem[k + 4] = 16'hFF00;
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        busy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({x_rd_en, w_rd_en, res_we, done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b expected 0000", {x_rd_en, w_rd_en, res_we, done});
        end
        vectors++;
        if ({x_addr, w_addr, res_addr, res_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: got x=%h w=%h ra=%h rd=%h expected all 0",
                     x_addr, w_addr, res_addr, res_data);
        end
        reset_b = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] exp_data [2];
        exp_data[0] = 16'd2560;
        exp_data[1] = 16'hF600;
        load_basic();
        do_run(16);
        vectors++;
        if (wr_cnt !== 2) begin
            miscompares++;
            $display("FAIL basic_wr_count: got %0d expected 2", wr_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (wr_addr[k] !== ADDR_W'(k) || wr_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL basic_result%0d: got addr %0d data %h expected addr %0d data %h",
                         k, wr_addr[k], wr_data[k], k, exp_data[k]);
            end
            vectors++;
            if (wr_cyc[k] !== 6 + 6 * k) begin
                miscompares++;
                $display("FAIL basic_store_cycle%0d: got %0d expected %0d", k, wr_cyc[k], 6 + 6 * k);
            end
        end
        vectors++;
        if (done_cnt !== 1 || done_cyc !== 13) begin
            miscompares++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d expected 1 at 13", done_cnt, done_cyc);
        end
        vectors++;
        if (rd_cnt !== 8) begin
            miscompares++;
            $display("FAIL basic_read_count: got %0d expected 8", rd_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (rd_x[k] !== ADDR_W'(k % 4) || rd_w[k] !== ADDR_W'(k)) begin
                miscompares++;
                $display("FAIL basic_read_addr%0d: got x=%0d w=%0d expected x=%0d w=%0d",
                         k, rd_x[k], rd_w[k], k % 4, k);
            end
        end
    endtask

    task automatic test_busy_held();
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({x_rd_en, w_rd_en, res_we, done} !== 4'b0000) begin
                miscompares++;
                $display("FAIL held_quiet%0d: got %b expected 0000", n, {x_rd_en, w_rd_en, res_we, done});
            end
        end
        idle_gap();
        do_run(16);
        vectors++;
        if (wr_cnt !== 2 || wr_data[0] !== 16'd2560 || wr_data[1] !== 16'hF600 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL held_rerun: got %0d writes %h %h done %0d expected 2 writes 0a00 f600 done 1",
                     wr_cnt, wr_data[0], wr_data[1], done_cnt);
        end
    endtask

    task automatic test_abort();
        int extra;
        idle_gap();
        busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (x_rd_en !== 1'b1 || x_addr !== ADDR_W'(2)) begin
            miscompares++;
            $display("FAIL abort_third_fetch: got en %b addr %0d expected en 1 addr 2", x_rd_en, x_addr);
        end
        busy = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({x_rd_en, w_rd_en, res_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_strobes: got %b expected 000", {x_rd_en, w_rd_en, res_we});
        end
        extra = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            if (res_we || done || x_rd_en) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", extra);
        end
        do_run(16);
        vectors++;
        if (wr_cnt !== 2 || wr_data[0] !== 16'd2560 || wr_data[1] !== 16'hF600 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL abort_rerun: got %0d writes %h %h done %0d expected 2 writes 0a00 f600 done 1",
                     wr_cnt, wr_data[0], wr_data[1], done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        idle_gap();
        busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_b = 1'b0;
        busy    = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({x_rd_en, w_rd_en, res_we, done, x_addr, w_addr, res_addr, res_data} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got en %b%b%b%b x=%h w=%h ra=%h rd=%h expected all 0",
                     x_rd_en, w_rd_en, res_we, done, x_addr, w_addr, res_addr, res_data);
        end
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        do_run(16);
        vectors++;
        if (wr_cnt !== 2 || wr_data[0] !== 16'd2560 || wr_data[1] !== 16'hF600 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL midreset_rerun: got %0d writes %h %h done %0d expected 2 writes 0a00 f600 done 1",
                     wr_cnt, wr_data[0], wr_data[1], done_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [DATA_W-1:0] exp0, exp1;
`ifdef LSTM_MAC_SAT_EN
        exp0 = 16'h7FFF;
        exp1 = 16'h8000;
`else
        exp0 = 16'hFC00;
        exp1 = 16'h0200;
`endif
        idle_gap();
        for (int k = 0; k < 4; k++) begin
            xmem[k]     = 16'h7FFF;
            wmem[k]     = 16'h7FFF;
            wmem[k + 4] = 16'h8000;
        end
        do_run(16);
        vectors++;
        if (wr_cnt !== 2 || wr_data[0] !== exp0) begin
            miscompares++;
            $display("FAIL sat_pos: got %h (%0d writes) expected %h", wr_data[0], wr_cnt, exp0);
        end
        vectors++;
        if (wr_data[1] !== exp1) begin
            miscompares++;
            $display("FAIL sat_neg: got %h expected %h", wr_data[1], exp1);
        end
    endtask

    task automatic test_neg_floor();
        idle_gap();
        xmem[0] = 16'hFFFF;
        for (int k = 1; k < 4; k++) xmem[k] = 16'h0000;
        wmem[0] = 16'h0001;
        for (int k = 1; k < 4; k++) wmem[k] = 16'h0000;
        for (int k = 4; k < 8; k++) wmem[k] = 16'h0001;
        do_run(16);
        vectors++;
        if (wr_cnt !== 2 || wr_data[0] !== 16'hFFFF || wr_data[1] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL neg_floor: got %h %h (%0d writes) expected ffff ffff", wr_data[0], wr_data[1], wr_cnt);
        end
    endtask

    initial begin
        reset_b = 1'b0;
        busy    = 1'b0;
        test_reset();
        test_basic();
        test_busy_held();
        test_abort();
        test_reset_mid();
        test_saturation();
        test_neg_floor();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lstm_mac_sequencer.md
Name: lstm_mac_sequencer

Overview:
- Datapath sequencer directly downstream of the run/busy control stage of the LSTM block.
- While `dut_xxx_busy` is high it computes NUM_OUT signed fixed-point dot products of length VEC_LEN: result[j] = sum over i of x[i]*w[j*VEC_LEN+i].
- Inputs come from an input-vector SRAM and a weight SRAM; each result is written to a result SRAM.
- Raises `dut_computation_done` when all results are stored, which clears busy in the control stage.

Parameters:
- DATA_W, 16, width of x, w and result words (signed, two's complement).
- FRAC_W, 8, number of fractional bits (Q-format) of x, w and result.
- ACC_W, 40, accumulator width (signed).
- ADDR_W, 12, SRAM address width.
- VEC_LEN, 8, elements per dot product (>=1).
- NUM_OUT, 4, number of dot products per run (>=1).

Ports:
- `clk`  input  1  system clock, all logic on rising edge
- `reset_b`  input  1  synchronous active-low reset
- `dut_xxx_busy`  input  1  busy level from the control stage
- `x_rd_en`  output  1  input-vector SRAM read strobe
- `x_addr`  output  ADDR_W  input-vector read address
- `x_rd_data`  input  DATA_W  input-vector data, valid 1 cycle after `x_rd_en`
- `w_rd_en`  output  1  weight SRAM read strobe
- `w_addr`  output  ADDR_W  weight read address
- `w_rd_data`  input  DATA_W  weight data, valid 1 cycle after `w_rd_en`
- `res_we`  output  1  result SRAM write enable
- `res_addr`  output  ADDR_W  result write address
- `res_data`  output  DATA_W  result write data
- `dut_computation_done`  output  1  single-cycle completion pulse

Behaviour:
- Reset (`reset_b` low at a rising edge):
  - state=IDLE.
  - All outputs 0; accumulator 0; counters i and j 0.
  - Reset applies in any state, including mid-run.
- All outputs are registered.
- States: IDLE, FETCH, DRAIN, STORE, DONE, WAIT_CLR.
- IDLE: when busy=1, go to FETCH with i=0, j=0, acc=0.
- FETCH:
  - Each cycle drive `x_rd_en`=`w_rd_en`=1, `x_addr`=i, `w_addr`=j*VEC_LEN+i; then i++.
  - After issuing i=VEC_LEN-1, go to DRAIN.
- Accumulation:
  - A 1-cycle delayed valid flag follows the read strobes.
  - When the flag is set: acc += sext(x_rd_data)*sext(w_rd_data), with a full 2*DATA_W product sign-extended to ACC_W.
  - Accumulation wraps at ACC_W; no overflow detection.
- DRAIN: one cycle, no reads; the final product is accumulated; go to STORE.
- STORE:
  - `res_we`=1 for one cycle, `res_addr`=j, `res_data`=convert(acc).
  - If j==NUM_OUT-1, go to DONE. Otherwise j++, i=0, acc=0, go to FETCH.
- convert(acc): arithmetic shift right by FRAC_W (floor toward -inf, no rounding), then reduce to DATA_W (see Optional Feature).
- Latency:
  - Per output: VEC_LEN+2 cycles (VEC_LEN FETCH, 1 DRAIN, 1 STORE).
  - First FETCH is the cycle after busy is sampled high.
  - `dut_computation_done` is high in the cycle after the last STORE.
- DONE: `dut_computation_done`=1 for exactly one cycle; go to WAIT_CLR.
- WAIT_CLR: stay until busy=0, then go to IDLE. This prevents a restart while the control stage holds busy because run is held high.
- Abort: if busy=0 in FETCH, DRAIN or STORE:
  - Go to IDLE next cycle.
  - Force strobes and `res_we` low that cycle.
  - No done pulse; acc and counters cleared.
- Strobes are 0 in every state except those listed above. Addresses and data hold their last value when strobes are low.
- Address arithmetic: j*VEC_LEN+i is computed at ADDR_W and truncated. Integration guarantees NUM_OUT*VEC_LEN <= 2^ADDR_W.

Optional Feature:
- Macro: `LSTM_MAC_SAT_EN`.
- Defined: the shifted accumulator saturates to DATA_W: values > 2^(DATA_W-1)-1 become 0x7FFF, values < -2^(DATA_W-1) become 0x8000 (DATA_W=16).
- Not defined: keep the low DATA_W bits of the shifted accumulator (wrap).

Test Plan:
- Basic run:
  - Setup: VEC_LEN=4, NUM_OUT=2; x=[256,512,768,1024]; w row0 all 256, row1 all -256.
  - Stimulus: pulse busy high.
  - Response: `res_we` writes addr0=2560 and addr1=-2560.
  - Timing: the two STOREs occur 6 and 12 cycles after the first FETCH; done is high 1 cycle, 13 cycles after the first FETCH.
- Saturation/wrap:
  - Setup: VEC_LEN=4; x and w all 32767.
  - With `LSTM_MAC_SAT_EN` defined: `res_data`=32767.
  - With it undefined: `res_data`=0xFC00 (-1024).
- Busy held:
  - Stimulus: keep busy high after done.
  - Response: FSM sits in WAIT_CLR with no strobes and no second done. After busy drops and rises again, a fresh run starts with acc=0.
- Abort:
  - Stimulus: drop busy on the 3rd FETCH cycle of output 0.
  - Response: strobes go low the next cycle; `res_we` never asserts; no done. The next busy produces correct results.
- Reset mid-run:
  - Stimulus: `reset_b`=0 for one edge during DRAIN.
  - Response: all outputs 0 the following cycle; state IDLE; the subsequent run yields correct results.
- Negative floor:
  - Setup: VEC_LEN=1, x=-1, w=1.
  - Response: acc=-1, so `res_data`=-1 (0xFFFF) and not 0.
